// File: rtl/audio_if_pkg.sv
// Shared constants for the audio sample bridge: bus address map and status
// register bit layout.
package audio_if_pkg;

    localparam int unsigned DEFAULT_DATA_SIZE = 28;

    typedef enum logic {
        ADDR_DATA   = 1'b0,
        ADDR_STATUS = 1'b1
    } addr_e;

    localparam int unsigned STATUS_EMPTY     = 0;
    localparam int unsigned STATUS_FULL      = 1;
    localparam int unsigned STATUS_OVF       = 2;
    localparam int unsigned STATUS_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Callers must qualify push/pop:
// push only when a slot is free (or a pop frees one), pop only when non-empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; pointers and count alone define validity.
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/audio_driver_interface.sv
// Streams audio samples into a FIFO and exposes them to the CPU through a
// registered read port with data and status registers.
module audio_driver_interface
    import audio_if_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = DEFAULT_DATA_SIZE,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 chipselect,
    input  logic                 address,
    input  logic                 read,
    input  logic                 source_valid,
    input  logic [DATA_SIZE-1:0] source_data,
    output logic                 source_ready,
    output logic [31:0]          read_data,
    output logic                 irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_SIZE-1:0] fifo_head;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    logic                 rd_data_sel;
    logic                 rd_status_sel;
    logic                 pop_en;
    logic                 push_en;
    logic                 ovf_set;
    logic [31:0]          status_word;

    logic [31:0]          read_data_q, read_data_d;
    logic                 ovf_q, ovf_d;

    assign rd_data_sel   = chipselect && read && (address == ADDR_DATA);
    assign rd_status_sel = chipselect && read && (address == ADDR_STATUS);
    assign pop_en        = rd_data_sel && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push_en       = source_valid && (!fifo_full || pop_en);
    assign ovf_set       = source_valid && !push_en;

    always_comb begin
        status_word                                 = '0;
        status_word[STATUS_COUNT_LSB +: 8]          = 8'(fifo_count);
        status_word[STATUS_OVF]                     = ovf_q;
        status_word[STATUS_FULL]                    = fifo_full;
        status_word[STATUS_EMPTY]                   = fifo_empty;
    end

    always_comb begin
        read_data_d = read_data_q;
        if (rd_data_sel) begin
            read_data_d = fifo_empty ? '0 : 32'(fifo_head);
        end else if (rd_status_sel) begin
            read_data_d = status_word;
        end
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (rd_status_sel) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            ovf_q       <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_en),
        .pop_i   (pop_en),
        .data_i  (source_data),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign read_data    = read_data_q;
    assign source_ready = 1'b1;
    assign irq          = 1'b0;

endmodule

// File: tb/tb_audio_driver_interface.sv
// Scoreboard bench: stimulus queues expected read results from a queue-based
// model of the sample buffer; a monitor compares after every clock edge.
module tb_audio_driver_interface;

    localparam int unsigned DW    = 28;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0;
    logic          addr = 1'b0;
    logic          rd = 1'b0;
    logic          sv = 1'b0;
    logic [DW-1:0] sd = '0;
    logic          source_ready;
    logic          irq;
    logic [31:0]   rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] expq  [$];
    logic [31:0] model [$];
    bit          ovf = 1'b0;
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    audio_driver_interface #(
        .DATA_SIZE  (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .chipselect   (cs),
        .address      (addr),
        .read         (rd),
        .source_valid (sv),
        .source_data  (sd),
        .source_ready (source_ready),
        .read_data    (rdata),
        .irq          (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, then advance the abstract model.
    task automatic step(input bit c, input bit a, input bit r, input bit v, input logic [31:0] d);
        bit          do_pop;
        bit          ovf_new;
        logic [31:0] st;
        logic [31:0] dv;
        do_pop  = 1'b0;
        ovf_new = 1'b0;
        dv      = d & ((32'd1 << DW) - 32'd1);
        @(negedge clk);
        cs = c; addr = a; rd = r; sv = v; sd = dv[DW-1:0];
        if (c && r) begin
            if (!a) begin
                if (model.size() > 0) begin
                    expq.push_back(model[0]);
                    do_pop = 1'b1;
                end else begin
                    expq.push_back(32'd0);
                end
            end else begin
                st = (32'(model.size()) << 8)
                   + (ovf ? 32'd4 : 32'd0)
                   + ((model.size() == DEPTH) ? 32'd2 : 32'd0)
                   + ((model.size() == 0) ? 32'd1 : 32'd0);
                expq.push_back(st);
            end
        end
        if (do_pop) void'(model.pop_front());
        if (v) begin
            if (model.size() < DEPTH) model.push_back(dv);
            else ovf_new = 1'b1;
        end
        if (c && r && a) ovf = ovf_new;
        else ovf = ovf | ovf_new;
    endtask

    task automatic do_reset(input int unsigned cycles);
        @(negedge clk);
        rst = 1'b1; sv = 1'b1; sd = 28'hAAAAAAA; cs = 1'b1; rd = 1'b1; addr = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0; sv = 1'b0; cs = 1'b0; rd = 1'b0;
        model.delete();
        ovf = 1'b0;
    endtask

    always @(posedge clk) begin
        bit          r_s;
        bit          rd_s;
        logic [31:0] e;
        r_s  = rst;
        rd_s = cs && rd;
        #1;
        if (r_s || rst) begin
            check("reset_read_data", rdata, 32'd0);
            last_exp = '0;
        end else if (rd_s) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow actual=%h required=<queued value>", rdata);
            end else begin
                e = expq.pop_front();
                check("read_data", rdata, e);
                last_exp = e;
            end
        end else begin
            check("read_hold", rdata, last_exp);
        end
    end

    always @(negedge clk) begin
        check("source_ready", {31'd0, source_ready}, 32'd1);
        check("irq", {31'd0, irq}, 32'd0);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single sample round trip, then status shows empty
        step(0, 0, 0, 1, 32'h1234567);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);

        // interleaved push/read ordering
        step(0, 0, 0, 1, 32'hABCDEF0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 32'h9876543);
        step(1, 0, 1, 0, 0);

        // burst of three, held read, then read from empty
        step(0, 0, 0, 1, 32'h1111111);
        step(0, 0, 0, 1, 32'h2222222);
        step(0, 0, 0, 1, 32'h3333333);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);

        // empty + push + data read returns 0 and stores the sample
        step(1, 0, 1, 1, 32'h0000055);
        step(1, 0, 1, 0, 0);

        // overflow: DEPTH+1 pushes, two status reads, drain
        for (int unsigned i = 0; i <= DEPTH; i++) step(0, 0, 0, 1, 32'h0100000 + i);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        // full + pop + push is accepted
        step(1, 0, 1, 1, 32'h0BEEF00);
        for (int unsigned i = 0; i <= DEPTH; i++) step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);

        // reset with a sample presented and a read asserted
        step(0, 0, 0, 1, 32'h0000777);
        do_reset(3);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);

        // randomized traffic with occasional resets
        for (int unsigned n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            end
        end

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
